// File: rtl/auth_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : auth_frame_pkg
// Description : Shared types, default constants and CRC8 helper for the
//               framed authentication command engine.
// Revision    : 1.0 - initial release
// ============================================================================
package auth_frame_pkg;

    // Session / frame FSM states
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_TX_READY   = 4'd1,
        S_RX_MAGIC   = 4'd2,
        S_RX_CMD     = 4'd3,
        S_RX_LEN     = 4'd4,
        S_RX_PAYLOAD = 4'd5,
        S_RX_CRC     = 4'd6,
        S_REQ        = 4'd7,
        S_RSP_WAIT   = 4'd8,
        S_TX_MAGIC   = 4'd9,
        S_TX_STATUS  = 4'd10,
        S_TX_CRC     = 4'd11,
        S_DONE       = 4'd12
    } frame_state_t;

    localparam logic [7:0] c_MAGIC_DFLT      = 8'hA5;
    localparam logic [7:0] c_READY_DFLT      = 8'h52;
    localparam logic [7:0] c_CRC8_POLY_DFLT  = 8'h07;
    localparam logic [7:0] c_ST_TIMEOUT_DFLT = 8'hEB;
    localparam logic [7:0] c_ST_BAD_CRC_DFLT = 8'hEF;
    localparam logic [7:0] c_ST_BAD_LEN_DFLT = 8'hED;

    // One byte of CRC8, MSB first, no reflection, no final xor
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic [7:0] data,
                                             input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timeout_timer
// Description : Up-counter with synchronous clear that flags expiry once it
//               has counted TIMEOUT_CYC cycles without a clear.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timeout_timer #(
    parameter int TIMEOUT_CYC = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired
);

    localparam int            c_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_W-1:0] c_LIMIT = c_W'(TIMEOUT_CYC);

    logic [c_W-1:0] r_count;

    // Count up to the limit and hold there until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (r_count != c_LIMIT) begin
            r_count <= r_count + c_W'(1);
        end
    end

    // A clear in the same cycle wins, so a fresh state or byte never expires
    assign expired = (r_count == c_LIMIT) && !clear;

endmodule
`default_nettype wire

// File: rtl/auth_frame_engine.sv
`default_nettype none
// ============================================================================
// Module      : auth_frame_engine
// Description : Wake-gated framed command engine. Sends READY, parses
//               MAGIC/CMD/LEN/PAYLOAD/CRC8 frames, forwards validated
//               commands on a valid/ready channel and answers with a
//               CRC-protected MAGIC/STATUS/CRC response.
//               Optional FRAME_STATS_EN adds saturating 16-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module auth_frame_engine
    import auth_frame_pkg::*;
#(
    parameter int         PAYLOAD_MAX = 16,
    parameter logic [7:0] MAGIC_BYTE  = c_MAGIC_DFLT,
    parameter logic [7:0] READY_BYTE  = c_READY_DFLT,
    parameter logic [7:0] CRC8_POLY   = c_CRC8_POLY_DFLT,
    parameter int         TIMEOUT_CYC = 270000,
    parameter logic [7:0] ST_TIMEOUT  = c_ST_TIMEOUT_DFLT,
    parameter logic [7:0] ST_BAD_CRC  = c_ST_BAD_CRC_DFLT,
    parameter logic [7:0] ST_BAD_LEN  = c_ST_BAD_LEN_DFLT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wake_n,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [7:0]               req_cmd,
    output logic [7:0]               req_len,
    output logic [8*PAYLOAD_MAX-1:0] req_payload,
    input  logic                     rsp_valid,
    input  logic [7:0]               rsp_status
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0]              stat_ok,
    output logic [15:0]              stat_crc_err,
    output logic [15:0]              stat_tmo
`endif
);

    localparam logic [7:0] c_PAYLOAD_MAX = 8'(PAYLOAD_MAX);

    frame_state_t             r_state;
    frame_state_t             r_state_q;
    logic                     r_tx_valid;
    logic [7:0]               r_tx_data;
    logic                     r_req_valid;
    logic [7:0]               r_cmd;
    logic [7:0]               r_len;
    logic [7:0]               r_idx;
    logic [7:0]               r_crc;
    logic [7:0]               r_status;
    logic [8*PAYLOAD_MAX-1:0] r_payload;

    logic       w_tmr_clear;
    logic       w_expired;
    logic       w_tmo;
    logic       w_tmo_report;
    logic       w_req_hs;
    logic       w_crc_bad;
    logic [7:0] w_crc_next;

    assign w_crc_next = crc8_step(r_crc, rx_data, CRC8_POLY);

    // Restart the timer on any byte, on entry to a new state, and while parked
    assign w_tmr_clear = rx_valid || (r_state != r_state_q) ||
                         (r_state == S_IDLE) || (r_state == S_DONE);

    frame_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_tmr_clear),
        .expired (w_expired)
    );

    // A dropped wake line outranks a timeout; only frame/back-end stalls report
    assign w_tmo        = !wake_n && w_expired;
    assign w_tmo_report = r_state inside {S_RX_CMD, S_RX_LEN, S_RX_PAYLOAD,
                                          S_RX_CRC, S_RSP_WAIT};
    assign w_req_hs     = !wake_n && !w_tmo && (r_state == S_REQ) && req_ready;
    assign w_crc_bad    = !wake_n && (r_state == S_RX_CRC) && rx_valid &&
                          (rx_data != r_crc);

    // Session FSM with registered TX and request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_state_q   <= S_IDLE;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_req_valid <= 1'b0;
            r_cmd       <= 8'h00;
            r_len       <= 8'h00;
            r_idx       <= 8'h00;
            r_crc       <= 8'h00;
            r_status    <= 8'h00;
            r_payload   <= '0;
        end else begin
            r_state_q <= r_state;
            if (wake_n) begin
                r_state     <= S_IDLE;
                r_tx_valid  <= 1'b0;
                r_req_valid <= 1'b0;
            end else if (w_tmo) begin
                r_req_valid <= 1'b0;
                if (w_tmo_report) begin
                    r_status   <= ST_TIMEOUT;
                    r_state    <= S_TX_MAGIC;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= MAGIC_BYTE;
                end else begin
                    r_state    <= S_DONE;
                    r_tx_valid <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_TX_READY;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= READY_BYTE;
                    end
                    S_TX_READY: if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_RX_MAGIC;
                    end
                    S_RX_MAGIC: if (rx_valid && rx_data == MAGIC_BYTE) begin
                        r_crc   <= 8'h00;
                        r_state <= S_RX_CMD;
                    end
                    S_RX_CMD: if (rx_valid) begin
                        r_cmd   <= rx_data;
                        r_crc   <= w_crc_next;
                        r_state <= S_RX_LEN;
                    end
                    S_RX_LEN: if (rx_valid) begin
                        r_len     <= rx_data;
                        r_crc     <= w_crc_next;
                        r_idx     <= 8'h00;
                        r_payload <= '0;
                        if (rx_data == 8'h00) begin
                            r_state <= S_RX_CRC;
                        end else if (rx_data > c_PAYLOAD_MAX) begin
                            r_status   <= ST_BAD_LEN;
                            r_state    <= S_TX_MAGIC;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= MAGIC_BYTE;
                        end else begin
                            r_state <= S_RX_PAYLOAD;
                        end
                    end
                    S_RX_PAYLOAD: if (rx_valid) begin
                        for (int i = 0; i < PAYLOAD_MAX; i++) begin
                            if (r_idx == 8'(i)) begin
                                r_payload[8*i +: 8] <= rx_data;
                            end
                        end
                        r_crc <= w_crc_next;
                        r_idx <= r_idx + 8'd1;
                        if (r_idx == r_len - 8'd1) begin
                            r_state <= S_RX_CRC;
                        end
                    end
                    S_RX_CRC: if (rx_valid) begin
                        if (w_crc_bad) begin
                            r_status   <= ST_BAD_CRC;
                            r_state    <= S_TX_MAGIC;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= MAGIC_BYTE;
                        end else begin
                            r_req_valid <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end
                    S_REQ: if (w_req_hs) begin
                        r_req_valid <= 1'b0;
                        if (rsp_valid) begin
                            r_status   <= rsp_status;
                            r_state    <= S_TX_MAGIC;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= MAGIC_BYTE;
                        end else begin
                            r_state <= S_RSP_WAIT;
                        end
                    end
                    S_RSP_WAIT: if (rsp_valid) begin
                        r_status   <= rsp_status;
                        r_state    <= S_TX_MAGIC;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= MAGIC_BYTE;
                    end
                    S_TX_MAGIC: if (tx_ready) begin
                        r_tx_data <= r_status;
                        r_state   <= S_TX_STATUS;
                    end
                    S_TX_STATUS: if (tx_ready) begin
                        r_tx_data <= crc8_step(8'h00, r_status, CRC8_POLY);
                        r_state   <= S_TX_CRC;
                    end
                    S_TX_CRC: if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_DONE;
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_tx_valid  <= 1'b0;
                        r_req_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign req_valid   = r_req_valid;
    assign req_cmd     = r_cmd;
    assign req_len     = r_len;
    assign req_payload = r_payload;

`ifdef FRAME_STATS_EN
    logic [15:0] r_stat_ok;
    logic [15:0] r_stat_crc_err;
    logic [15:0] r_stat_tmo;

    // Saturating event counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ok      <= 16'h0000;
            r_stat_crc_err <= 16'h0000;
            r_stat_tmo     <= 16'h0000;
        end else begin
            if (w_req_hs && r_stat_ok != 16'hFFFF) begin
                r_stat_ok <= r_stat_ok + 16'd1;
            end
            if (w_crc_bad && r_stat_crc_err != 16'hFFFF) begin
                r_stat_crc_err <= r_stat_crc_err + 16'd1;
            end
            if (w_tmo && r_stat_tmo != 16'hFFFF) begin
                r_stat_tmo <= r_stat_tmo + 16'd1;
            end
        end
    end

    assign stat_ok      = r_stat_ok;
    assign stat_crc_err = r_stat_crc_err;
    assign stat_tmo     = r_stat_tmo;
`endif

endmodule
`default_nettype wire
